// File: rtl/ulpi_phy_reg_resp.sv
// Purpose: PHY side of the ULPI register-access protocol (TX CMD reg read/write) plus RX CMD emission.
// Latency: write commits on the cycle after STP is seen; read data drives the bus 3 cycles after the cmd byte.
// Backpressure: link is throttled with ULPI_NXT; RX CMD requests wait in IDLE while a register access is served.
//
// Ports:
//   CLK_60M, NRST_A_USB          ULPI clock, async active-low reset
//   ULPI_DATA_I/O/OE, ULPI_DIR,  ULPI bus (PHY side); DIR=1 means PHY owns the bus
//   ULPI_NXT, ULPI_STP
//   RXCMD_REQ/VAL/BUSY           one-shot RX CMD request, byte, in-progress flag
//   REG_WR_STB/ADDR/DATA         committed register write pulse and its address/data
//   FUNC_CTRL, IFACE_CTRL        live register contents
module ulpi_phy_reg_resp #(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0006
) (
    input  logic       CLK_60M,
    input  logic       NRST_A_USB,
    input  logic [7:0] ULPI_DATA_I,
    output logic [7:0] ULPI_DATA_O,
    output logic       ULPI_DATA_OE,
    output logic       ULPI_DIR,
    output logic       ULPI_NXT,
    input  logic       ULPI_STP,
    input  logic       RXCMD_REQ,
    input  logic [7:0] RXCMD_VAL,
    output logic       RXCMD_BUSY,
    output logic       REG_WR_STB,
    output logic [5:0] REG_WR_ADDR,
    output logic [7:0] REG_WR_DATA,
    output logic [7:0] FUNC_CTRL,
    output logic [7:0] IFACE_CTRL
);

    typedef enum logic [3:0] {
        IDLE, W_ACK, W_DATA, W_STP, R_ACK, R_TURN1, R_DATA, R_TURN2,
        X_TURN1, X_DATA, X_TURN2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [5:0] addr_q;
    logic [7:0] wdat_q;
    logic [7:0] rxcmd_q;
    logic [7:0] otg_ctrl;
    logic [7:0] scratch;

    logic       cmd_vld;
    logic       cmd_rd;
    logic       commit;
    logic [7:0] rd_val;

    logic [7:0] func_nxt;
    logic [7:0] iface_nxt;
    logic [7:0] otg_nxt;
    logic [7:0] scratch_nxt;

    logic       dir_d;
    logic       oe_d;
    logic       nxt_d;
    logic       busy_d;
    logic [7:0] dat_d;

    // Only register read/write commands are honoured; transmit (01) and the
    // extended-address escape (0x2F) are left for the link to retry elsewhere.
    assign cmd_vld = ULPI_DATA_I[7] && (ULPI_DATA_I[5:0] != 6'h2F);
    assign cmd_rd  = ULPI_DATA_I[6];
    assign commit  = (state == W_STP) && ULPI_STP;

    // Group op: offset 0 = load, 1 = set bits, 2 = clear bits.
    function automatic logic [7:0] grp_upd(input logic [7:0] cur,
                                           input logic [1:0] op,
                                           input logic [7:0] d);
        case (op)
            2'd0:    grp_upd = d;
            2'd1:    grp_upd = cur | d;
            2'd2:    grp_upd = cur & ~d;
            default: grp_upd = cur;
        endcase
    endfunction

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_vld) begin
                    state_nxt = cmd_rd ? R_ACK : W_ACK;
                end else if (RXCMD_REQ) begin
                    state_nxt = X_TURN1;
                end
            end
            W_ACK:   state_nxt = ULPI_STP ? IDLE : W_DATA;
            W_DATA:  state_nxt = ULPI_STP ? IDLE : W_STP;
            W_STP:   state_nxt = ULPI_STP ? IDLE : W_STP;
            R_ACK:   state_nxt = ULPI_STP ? IDLE : R_TURN1;
            R_TURN1: state_nxt = R_DATA;
            R_DATA:  state_nxt = R_TURN2;
            R_TURN2: state_nxt = IDLE;
            X_TURN1: state_nxt = X_DATA;
            X_DATA:  state_nxt = X_TURN2;
            X_TURN2: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic: decoded from the next state so every bus output
    // is a flop that lines up with the state it belongs to.
    // ---------------------------------------------------------------
    always_comb begin
        nxt_d  = (state_nxt == W_ACK) || (state_nxt == W_DATA) || (state_nxt == R_ACK);
        dir_d  = (state_nxt == R_TURN1) || (state_nxt == R_DATA) ||
                 (state_nxt == X_TURN1) || (state_nxt == X_DATA);
        oe_d   = (state_nxt == R_DATA) || (state_nxt == X_DATA);
        busy_d = (state_nxt == X_TURN1) || (state_nxt == X_DATA) || (state_nxt == X_TURN2);
        dat_d  = 8'h00;
        if (state_nxt == R_DATA) begin
            dat_d = rd_val;
        end else if (state_nxt == X_DATA) begin
            dat_d = rxcmd_q;
        end
    end

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            ULPI_NXT     <= 1'b0;
            ULPI_DIR     <= 1'b0;
            ULPI_DATA_OE <= 1'b0;
            ULPI_DATA_O  <= 8'h00;
            RXCMD_BUSY   <= 1'b0;
        end else begin
            ULPI_NXT     <= nxt_d;
            ULPI_DIR     <= dir_d;
            ULPI_DATA_OE <= oe_d;
            ULPI_DATA_O  <= dat_d;
            RXCMD_BUSY   <= busy_d;
        end
    end

    // ---------------------------------------------------------------
    // Transfer capture: command address, write data, RX CMD byte
    // ---------------------------------------------------------------
    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            addr_q  <= 6'h00;
            wdat_q  <= 8'h00;
            rxcmd_q <= 8'h00;
        end else begin
            if (state == IDLE) begin
                if (cmd_vld) begin
                    addr_q <= ULPI_DATA_I[5:0];
                end else if (RXCMD_REQ) begin
                    rxcmd_q <= RXCMD_VAL;
                end
            end
            if ((state == W_DATA) && !ULPI_STP) begin
                wdat_q <= ULPI_DATA_I;
            end
        end
    end

    // ---------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------
    always_comb begin
        case (addr_q)
            6'h00:                rd_val = VENDOR_ID[7:0];
            6'h01:                rd_val = VENDOR_ID[15:8];
            6'h02:                rd_val = PRODUCT_ID[7:0];
            6'h03:                rd_val = PRODUCT_ID[15:8];
            6'h04, 6'h05, 6'h06:  rd_val = FUNC_CTRL;
            6'h07, 6'h08, 6'h09:  rd_val = IFACE_CTRL;
            6'h0A, 6'h0B, 6'h0C:  rd_val = otg_ctrl;
            6'h16, 6'h17, 6'h18:  rd_val = scratch;
            default:              rd_val = 8'h00;
        endcase
    end

    always_comb begin
        func_nxt    = FUNC_CTRL;
        iface_nxt   = IFACE_CTRL;
        otg_nxt     = otg_ctrl;
        scratch_nxt = scratch;
        // The Reset bit is a strobe: visible for one cycle, then cleared.
        func_nxt[5] = 1'b0;
        if (commit) begin
            case (addr_q)
                6'h04:   func_nxt    = grp_upd(FUNC_CTRL, 2'd0, wdat_q);
                6'h05:   func_nxt    = grp_upd(FUNC_CTRL, 2'd1, wdat_q);
                6'h06:   func_nxt    = grp_upd(FUNC_CTRL, 2'd2, wdat_q);
                6'h07:   iface_nxt   = grp_upd(IFACE_CTRL, 2'd0, wdat_q);
                6'h08:   iface_nxt   = grp_upd(IFACE_CTRL, 2'd1, wdat_q);
                6'h09:   iface_nxt   = grp_upd(IFACE_CTRL, 2'd2, wdat_q);
                6'h0A:   otg_nxt     = grp_upd(otg_ctrl, 2'd0, wdat_q);
                6'h0B:   otg_nxt     = grp_upd(otg_ctrl, 2'd1, wdat_q);
                6'h0C:   otg_nxt     = grp_upd(otg_ctrl, 2'd2, wdat_q);
                6'h16:   scratch_nxt = grp_upd(scratch, 2'd0, wdat_q);
                6'h17:   scratch_nxt = grp_upd(scratch, 2'd1, wdat_q);
                6'h18:   scratch_nxt = grp_upd(scratch, 2'd2, wdat_q);
                default: ; // read-only or unmapped: handshake only
            endcase
        end
    end

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            FUNC_CTRL   <= 8'h41;
            IFACE_CTRL  <= 8'h00;
            otg_ctrl    <= 8'h06;
            scratch     <= 8'h00;
            REG_WR_STB  <= 1'b0;
            REG_WR_ADDR <= 6'h00;
            REG_WR_DATA <= 8'h00;
        end else begin
            FUNC_CTRL   <= func_nxt;
            IFACE_CTRL  <= iface_nxt;
            otg_ctrl    <= otg_nxt;
            scratch     <= scratch_nxt;
            REG_WR_STB  <= commit;
            if (commit) begin
                REG_WR_ADDR <= addr_q;
                REG_WR_DATA <= wdat_q;
            end
        end
    end

endmodule

// File: tb/tb_ulpi_phy_reg_resp.sv
// Purpose: self-checking bench for ulpi_phy_reg_resp (register reads/writes, RX CMD, aborts, reset).
// Latency: checks cycle-exact ULPI handshake timing for every transaction.
// Backpressure: drives the link side as a well-behaved ULPI link honouring NXT/DIR.
module tb_ulpi_phy_reg_resp;

    logic       CLK_60M = 1'b0;
    logic       NRST_A_USB = 1'b0;
    logic [7:0] ULPI_DATA_I = 8'h00;
    logic [7:0] ULPI_DATA_O;
    logic       ULPI_DATA_OE;
    logic       ULPI_DIR;
    logic       ULPI_NXT;
    logic       ULPI_STP = 1'b0;
    logic       RXCMD_REQ = 1'b0;
    logic [7:0] RXCMD_VAL = 8'h00;
    logic       RXCMD_BUSY;
    logic       REG_WR_STB;
    logic [5:0] REG_WR_ADDR;
    logic [7:0] REG_WR_DATA;
    logic [7:0] FUNC_CTRL;
    logic [7:0] IFACE_CTRL;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];

    ulpi_phy_reg_resp dut (
        .CLK_60M      (CLK_60M),
        .NRST_A_USB   (NRST_A_USB),
        .ULPI_DATA_I  (ULPI_DATA_I),
        .ULPI_DATA_O  (ULPI_DATA_O),
        .ULPI_DATA_OE (ULPI_DATA_OE),
        .ULPI_DIR     (ULPI_DIR),
        .ULPI_NXT     (ULPI_NXT),
        .ULPI_STP     (ULPI_STP),
        .RXCMD_REQ    (RXCMD_REQ),
        .RXCMD_VAL    (RXCMD_VAL),
        .RXCMD_BUSY   (RXCMD_BUSY),
        .REG_WR_STB   (REG_WR_STB),
        .REG_WR_ADDR  (REG_WR_ADDR),
        .REG_WR_DATA  (REG_WR_DATA),
        .FUNC_CTRL    (FUNC_CTRL),
        .IFACE_CTRL   (IFACE_CTRL)
    );

    always #5 CLK_60M = ~CLK_60M;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK_60M);
        #1;
    endtask

    // Scoreboard: every byte the PHY places on the bus must match the next queued one.
    always @(posedge CLK_60M) begin
        #1;
        if (ULPI_DATA_OE === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_byte", {24'h0, ULPI_DATA_O}, 32'hFFFF_FFFF);
            end else begin
                chk("bus_data", {24'h0, ULPI_DATA_O}, {24'h0, sb.pop_front()});
            end
        end
    end

    task automatic reg_write(input logic [7:0] cmd, input logic [7:0] dat,
                             input logic [7:0] exp_func);
        ULPI_DATA_I = cmd;
        tick();                                  // E0 -> W_ACK
        chk("wr_nxt_ack", ULPI_NXT, 1);
        chk("wr_dir_ack", ULPI_DIR, 0);
        ULPI_DATA_I = dat;
        tick();                                  // E1 -> W_DATA
        chk("wr_nxt_data", ULPI_NXT, 1);
        tick();                                  // E2 -> W_STP, data sampled
        chk("wr_nxt_stp", ULPI_NXT, 0);
        chk("wr_stb_early", REG_WR_STB, 0);
        ULPI_DATA_I = 8'h00;
        ULPI_STP    = 1'b1;
        tick();                                  // commit
        ULPI_STP    = 1'b0;
        chk("wr_stb", REG_WR_STB, 1);
        chk("wr_addr", REG_WR_ADDR, cmd[5:0]);
        chk("wr_data", REG_WR_DATA, dat);
        chk("wr_func", FUNC_CTRL, exp_func);
        tick();
        chk("wr_stb_once", REG_WR_STB, 0);
    endtask

    task automatic reg_read(input logic [7:0] cmd, input logic [7:0] exp);
        sb.push_back(exp);
        ULPI_DATA_I = cmd;
        tick();                                  // R_ACK
        chk("rd_nxt_ack", ULPI_NXT, 1);
        chk("rd_dir_ack", ULPI_DIR, 0);
        ULPI_DATA_I = 8'h00;
        tick();                                  // R_TURN1
        chk("rd_dir_t1", ULPI_DIR, 1);
        chk("rd_oe_t1", ULPI_DATA_OE, 0);
        chk("rd_nxt_t1", ULPI_NXT, 0);
        tick();                                  // R_DATA (byte checked by scoreboard)
        chk("rd_dir_data", ULPI_DIR, 1);
        chk("rd_oe_data", ULPI_DATA_OE, 1);
        tick();                                  // R_TURN2
        chk("rd_dir_t2", ULPI_DIR, 0);
        chk("rd_oe_t2", ULPI_DATA_OE, 0);
        tick();                                  // IDLE
    endtask

    typedef struct {
        logic       is_rd;
        logic [7:0] cmd;
        logic [7:0] dat;
        logic [7:0] exp;   // read: bus byte; write: FUNC_CTRL right after commit
    } vec_t;

    vec_t vecs[27];

    initial begin : main
        int busy_cnt;
        int dir_cnt;

        vecs[0]  = '{1'b1, 8'hC0, 8'h00, 8'h24};
        vecs[1]  = '{1'b1, 8'hC1, 8'h00, 8'h04};
        vecs[2]  = '{1'b1, 8'hC2, 8'h00, 8'h06};
        vecs[3]  = '{1'b1, 8'hC3, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 8'hC4, 8'h00, 8'h41};
        vecs[5]  = '{1'b1, 8'hCA, 8'h00, 8'h06};
        vecs[6]  = '{1'b1, 8'hD6, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 8'h84, 8'h45, 8'h45};
        vecs[8]  = '{1'b1, 8'hC4, 8'h00, 8'h45};
        vecs[9]  = '{1'b1, 8'hC5, 8'h00, 8'h45};
        vecs[10] = '{1'b0, 8'h96, 8'h0F, 8'h45};
        vecs[11] = '{1'b0, 8'h97, 8'hF0, 8'h45};
        vecs[12] = '{1'b1, 8'hD6, 8'h00, 8'hFF};
        vecs[13] = '{1'b0, 8'h98, 8'h0F, 8'h45};
        vecs[14] = '{1'b1, 8'hD6, 8'h00, 8'hF0};
        vecs[15] = '{1'b0, 8'h87, 8'h81, 8'h45};
        vecs[16] = '{1'b1, 8'hC7, 8'h00, 8'h81};
        vecs[17] = '{1'b0, 8'h89, 8'h01, 8'h45};
        vecs[18] = '{1'b1, 8'hC8, 8'h00, 8'h80};
        vecs[19] = '{1'b0, 8'h80, 8'h55, 8'h45};
        vecs[20] = '{1'b1, 8'hC0, 8'h00, 8'h24};
        vecs[21] = '{1'b0, 8'h9F, 8'h12, 8'h45};
        vecs[22] = '{1'b1, 8'hDF, 8'h00, 8'h00};
        vecs[23] = '{1'b0, 8'h8C, 8'h02, 8'h45};
        vecs[24] = '{1'b1, 8'hCA, 8'h00, 8'h04};
        vecs[25] = '{1'b0, 8'h85, 8'h20, 8'h65};
        vecs[26] = '{1'b1, 8'hC4, 8'h00, 8'h45};

        // Reset state
        repeat (2) tick();
        chk("rst_dir", ULPI_DIR, 0);
        chk("rst_nxt", ULPI_NXT, 0);
        chk("rst_oe", ULPI_DATA_OE, 0);
        chk("rst_dato", ULPI_DATA_O, 0);
        chk("rst_busy", RXCMD_BUSY, 0);
        chk("rst_stb", REG_WR_STB, 0);
        chk("rst_waddr", REG_WR_ADDR, 0);
        chk("rst_wdata", REG_WR_DATA, 0);
        chk("rst_func", FUNC_CTRL, 8'h41);
        chk("rst_iface", IFACE_CTRL, 8'h00);
        #2 NRST_A_USB = 1'b1;
        tick();

        // Table-driven register traffic
        for (int i = 0; i < 27; i++) begin
            if (vecs[i].is_rd) reg_read(vecs[i].cmd, vecs[i].exp);
            else               reg_write(vecs[i].cmd, vecs[i].dat, vecs[i].exp);
        end
        chk("iface_port", IFACE_CTRL, 8'h80);

        // Write aborted by STP in W_DATA
        ULPI_DATA_I = 8'h84;
        tick();
        ULPI_DATA_I = 8'h99;
        tick();
        ULPI_STP = 1'b1;
        tick();
        ULPI_STP = 1'b0;
        ULPI_DATA_I = 8'h00;
        chk("abort_nxt", ULPI_NXT, 0);
        tick();
        chk("abort_stb", REG_WR_STB, 0);
        chk("abort_func", FUNC_CTRL, 8'h45);

        // Ignored commands: transmit and extended address
        ULPI_DATA_I = 8'h40;
        tick();
        chk("tx40_nxt", ULPI_NXT, 0);
        ULPI_DATA_I = 8'hAF;
        tick();
        chk("axf_nxt", ULPI_NXT, 0);
        ULPI_DATA_I = 8'h00;
        tick();
        chk("ign_nxt", ULPI_NXT, 0);
        chk("ign_dir", ULPI_DIR, 0);

        // Read and RX CMD requested together: read first, then RX CMD
        RXCMD_REQ = 1'b1;
        RXCMD_VAL = 8'h4D;
        reg_read(8'hC4, 8'h45);
        sb.push_back(8'h4D);
        busy_cnt = 0;
        dir_cnt  = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (RXCMD_BUSY) begin
                busy_cnt++;
                RXCMD_REQ = 1'b0;
            end
            if (ULPI_DIR) dir_cnt++;
        end
        RXCMD_REQ = 1'b0;
        chk("rxcmd_busy_cycles", busy_cnt, 3);
        chk("rxcmd_dir_cycles", dir_cnt, 2);
        chk("rxcmd_sb_drained", sb.size(), 0);

        // Reset during R_DATA
        sb.push_back(8'h45);
        ULPI_DATA_I = 8'hC4;
        tick();
        ULPI_DATA_I = 8'h00;
        tick();
        tick();                                  // R_DATA
        chk("pre_rst_oe", ULPI_DATA_OE, 1);
        #2 NRST_A_USB = 1'b0;
        #1;
        chk("async_rst_dir", ULPI_DIR, 0);
        chk("async_rst_oe", ULPI_DATA_OE, 0);
        chk("async_rst_nxt", ULPI_NXT, 0);
        chk("async_rst_func", FUNC_CTRL, 8'h41);
        #3 NRST_A_USB = 1'b1;
        tick();
        chk("post_rst_iface", IFACE_CTRL, 8'h00);
        reg_read(8'hC7, 8'h00);
        reg_read(8'hD6, 8'h00);
        reg_read(8'hCA, 8'h06);
        reg_read(8'hC4, 8'h41);

        repeat (2) tick();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
